// File: rtl/ex_muldiv.sv
// Execute stage: combinational logic/move ops with HI/LO forwarding, plus
// iterative shift-add multiply and restoring divide that stall the pipeline.
module ex_muldiv #(
   parameter int DW    = 32,
   parameter int CNT_W = $clog2(DW) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic [2:0]    alusel_i,
   input  logic [7:0]    aluop_i,
   input  logic [DW-1:0] reg1_i,
   input  logic [DW-1:0] reg2_i,
   input  logic [4:0]    wd_i,
   input  logic          wreg_i,
   input  logic [DW-1:0] hi_i,
   input  logic [DW-1:0] lo_i,
   input  logic          mem_whilo_i,
   input  logic [DW-1:0] mem_hi_i,
   input  logic [DW-1:0] mem_lo_i,
   input  logic          wb_whilo_i,
   input  logic [DW-1:0] wb_hi_i,
   input  logic [DW-1:0] wb_lo_i,
   output logic [4:0]    wd_o,
   output logic          wreg_o,
   output logic [DW-1:0] wdata_o,
   output logic          whilo_o,
   output logic [DW-1:0] hi_o,
   output logic [DW-1:0] lo_o,
   output logic          stallreq_o
);

   localparam logic [2:0] SEL_LOGIC  = 3'b001;
   localparam logic [2:0] SEL_MOVE   = 3'b011;

   localparam logic [7:0] OP_AND   = 8'b00100100;
   localparam logic [7:0] OP_OR    = 8'b00100101;
   localparam logic [7:0] OP_XOR   = 8'b00100110;
   localparam logic [7:0] OP_NOR   = 8'b00100111;
   localparam logic [7:0] OP_ANDI  = 8'b01011001;
   localparam logic [7:0] OP_ORI   = 8'b01011010;
   localparam logic [7:0] OP_XORI  = 8'b01011011;
   localparam logic [7:0] OP_LUI   = 8'b01011100;
   localparam logic [7:0] OP_MFHI  = 8'b00010000;
   localparam logic [7:0] OP_MTHI  = 8'b00010001;
   localparam logic [7:0] OP_MFLO  = 8'b00010010;
   localparam logic [7:0] OP_MTLO  = 8'b00010011;
   localparam logic [7:0] OP_MULT  = 8'b00011000;
   localparam logic [7:0] OP_MULTU = 8'b00011001;
   localparam logic [7:0] OP_DIV   = 8'b00011010;
   localparam logic [7:0] OP_DIVU  = 8'b00011011;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   function automatic logic [DW-1:0] f_abs(input logic [DW-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   logic [1:0]      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]      r_op;
   logic            r_neg_q;
   logic            r_neg_r;
   logic [2*DW-1:0] r_mcand;
   logic [2*DW-1:0] r_acc;
   logic [DW-1:0]   r_mplr;
   logic [DW-1:0]   r_dvd;
   logic [DW-1:0]   r_dvs;
   logic [DW-1:0]   r_rem;

   logic [DW-1:0]   w_hi;
   logic [DW-1:0]   w_lo;
   logic [DW-1:0]   w_logic;
   logic [DW-1:0]   w_move;
   logic            w_is_mul;
   logic            w_is_div;
   logic            w_is_md;
   logic            w_signed;
   logic [DW-1:0]   w_mag1;
   logic [DW-1:0]   w_mag2;
   logic            w_last;
   logic [DW:0]     w_shift;
   logic [DW:0]     w_trial;
   logic [2*DW-1:0] w_prod;
   logic [DW-1:0]   w_quo;
   logic [DW-1:0]   w_remr;
   logic            w_done_div;

   assign w_hi = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
   assign w_lo = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

   always_comb begin
      w_logic = '0;
      case (aluop_i)
         OP_AND, OP_ANDI: w_logic = reg1_i & reg2_i;
         OP_OR,  OP_ORI:  w_logic = reg1_i | reg2_i;
         OP_XOR, OP_XORI: w_logic = reg1_i ^ reg2_i;
         OP_NOR:          w_logic = ~(reg1_i | reg2_i);
         OP_LUI:          w_logic = reg2_i;
         default:         w_logic = '0;
      endcase
   end

   always_comb begin
      w_move = '0;
      case (aluop_i)
         OP_MFHI: w_move = w_hi;
         OP_MFLO: w_move = w_lo;
         default: w_move = '0;
      endcase
   end

   assign w_is_mul = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
   assign w_is_div = (aluop_i == OP_DIV)  || (aluop_i == OP_DIVU);
   assign w_is_md  = w_is_mul || w_is_div;
   assign w_signed = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
   assign w_mag1   = f_abs(reg1_i, w_signed & reg1_i[DW-1]);
   assign w_mag2   = f_abs(reg2_i, w_signed & reg2_i[DW-1]);
   assign w_last   = (r_cnt == CNT_W'(DW - 1));

   // Restoring step: bring in the next dividend bit, keep the difference if it did not borrow.
   assign w_shift  = {r_rem, r_dvd[DW-1]};
   assign w_trial  = w_shift - {1'b0, r_dvs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_mcand <= '0;
         r_acc   <= '0;
         r_mplr  <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_rem   <= '0;
      end else if (flush_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_mcand <= '0;
         r_acc   <= '0;
         r_mplr  <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_rem   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_md) begin
                  r_op    <= aluop_i;
                  r_cnt   <= '0;
                  r_neg_q <= w_signed & (reg1_i[DW-1] ^ reg2_i[DW-1]);
                  r_neg_r <= w_signed & reg1_i[DW-1];
                  r_mcand <= {{DW{1'b0}}, w_mag1};
                  r_mplr  <= w_mag2;
                  r_acc   <= '0;
                  r_dvs   <= w_mag2;
                  r_rem   <= '0;
                  if (w_is_mul) begin
                     r_dvd   <= w_mag1;
                     r_state <= S_MUL;
                  end else if (reg2_i == '0) begin
                     r_dvd   <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_dvd   <= w_mag1;
                     r_state <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               if (r_mplr[0]) r_acc <= r_acc + r_mcand;
               r_mcand <= r_mcand << 1;
               r_mplr  <= r_mplr >> 1;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) r_state <= S_DONE;
            end
            S_DIV: begin
               r_rem   <= w_trial[DW] ? w_shift[DW-1:0] : w_trial[DW-1:0];
               r_dvd   <= {r_dvd[DW-2:0], ~w_trial[DW]};
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_done_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
   assign w_prod     = r_neg_q ? -r_acc : r_acc;
   assign w_quo      = r_neg_q ? -r_dvd : r_dvd;
   assign w_remr     = r_neg_r ? -r_rem : r_rem;

   // All outputs are forced low while reset is held, including the pass-through fields.
   always_comb begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
      if (rst_n) begin
         wd_o   = wd_i;
         wreg_o = wreg_i;
         if (alusel_i == SEL_LOGIC)     wdata_o = w_logic;
         else if (alusel_i == SEL_MOVE) wdata_o = w_move;
         stallreq_o = !flush_i && ((r_state == S_MUL) || (r_state == S_DIV) ||
                                   ((r_state == S_IDLE) && w_is_md));
         if ((r_state == S_DONE) && !flush_i) begin
            whilo_o = 1'b1;
            hi_o    = w_done_div ? w_remr : w_prod[2*DW-1:DW];
            lo_o    = w_done_div ? w_quo  : w_prod[DW-1:0];
         end else if (aluop_i == OP_MTHI) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = w_lo;
         end else if (aluop_i == OP_MTLO) begin
            whilo_o = 1'b1;
            hi_o    = w_hi;
            lo_o    = reg1_i;
         end
      end
   end

endmodule
